seq_control_unit: RTL and testbench
===================================

SEQ_CONTROL_UNIT -- requirements
Module: seq_control_unit

Interface
REQ-001 Parameter INSTR_W, default 16, instruction width; SHALL be >= 4 + 2*REG_ADR_W + MEM_ADR_W.
REQ-002 Parameter REG_ADR_W, default 2, register-select width.
REQ-003 Parameter MEM_ADR_W, default 8, memory/jump address width.
REQ-004 Parameter MEM_TIMEOUT, default 15, maximum MEM-state wait cycles before trap; used only when SEQ_CTRL_TRAP_EN is defined.
REQ-005 One clock; reset is asynchronous and active-low: clk input 1 rising-edge clock; rst_n input 1 async active-low reset.
REQ-006 instr_valid input 1, instruction offered; instr_ready output 1, block can accept; instr input INSTR_W, instruction word.
REQ-007 alu_code output 4, ALU operation; alu_flag input 1, ALU branch condition result.
REQ-008 reg1 and reg2 outputs, each REG_ADR_W wide, register selects; reg_read output 1; reg_write output 1.
REQ-009 mem_req output 1; mem_we output 1; mem_adr output MEM_ADR_W; mem_ack input 1, transfer complete.
REQ-010 pc_jump output 1, one-cycle PC load strobe; pc_target output MEM_ADR_W; busy output 1, high outside IDLE; trap output 1, sticky fault.

Function
REQ-011 Fields of the captured word: opcode = top 4 bits; rs1 = next REG_ADR_W bits; rs2 = next REG_ADR_W bits; adr = low MEM_ADR_W bits.
REQ-012 Opcodes SHALL be: ADD 0000 (alu 1000), SUB 0010 (alu 0100), LOAD 0100 (alu 1001), STORE 0110 (alu 1001), JUMP 1000, BRANCH 1101/1110/1111 (alu_code = opcode).
REQ-013 FSM states SHALL be IDLE, DECODE, EXEC, MEM, WB and TRAP.
REQ-014 IDLE: instr_ready=1; on instr_valid&&instr_ready, instr is captured into an internal register and the FSM enters DECODE; otherwise it stays in IDLE.
REQ-015 DECODE (1 cycle): reg1=rs1, reg2=rs2 and reg_read=1 for ADD/SUB/STORE/BRANCH; reg1=rs1 only for LOAD; next state EXEC.
REQ-016 EXEC (1 cycle): alu_code is driven. ADD/SUB go to WB; LOAD/STORE go to MEM; JUMP drives pc_jump=1, pc_target=adr and returns to IDLE; BRANCH drives pc_jump=alu_flag, pc_target=adr and returns to IDLE.
REQ-017 MEM: mem_req=1, mem_adr=adr, mem_we=1 for STORE only, all held stable until the cycle mem_ack=1. On that cycle LOAD goes to WB and STORE goes to IDLE.
REQ-018 mem_ack outside MEM SHALL be ignored.
REQ-019 WB (1 cycle): reg_write=1 and reg1=rs1, then IDLE.
REQ-020 Latency: ADD/SUB reg_write is asserted 3 cycles after the accept edge. JUMP/BRANCH pc_jump is asserted 2 cycles after accept. LOAD reg_write is asserted 1 cycle after mem_ack.
REQ-021 Outputs are Moore functions of state and the captured instruction. Outputs not driven by the current state SHALL be 0; outputs never take X.
REQ-022 instr_ready=0 in every state except IDLE; a new instruction is never accepted while busy.
REQ-023 instr and instr_valid changes while busy SHALL have no effect.

Reset
REQ-024 rst_n low SHALL force, asynchronously, state=IDLE, instruction register=0, timeout counter=0 and trap=0.
REQ-025 While rst_n is low, all outputs SHALL be 0, including instr_ready.
REQ-026 Reset asserted mid-MEM SHALL drop mem_req immediately; a later mem_ack is ignored.
REQ-027 After rst_n deasserts, the block SHALL be in IDLE with instr_ready=1 on the next cycle.

Configuration
REQ-028 Macro SEQ_CTRL_TRAP_EN: when defined, an undefined opcode in DECODE goes to TRAP.
REQ-029 With SEQ_CTRL_TRAP_EN defined, MEM waiting MEM_TIMEOUT cycles without mem_ack goes to TRAP.
REQ-030 TRAP holds trap=1, busy=1 and instr_ready=0 until reset.
REQ-031 Without SEQ_CTRL_TRAP_EN, an undefined opcode SHALL be a NOP (DECODE to IDLE, no strobes); there is no timeout counter; MEM waits indefinitely; trap is tied to 0.

Structure
REQ-032 Shared package ctrl_pkg SHALL hold the opcode constants, ALU code constants and the state enumeration typedef.
REQ-033 Opcode-to-control decoding SHALL live in a combinational sub-module ctrl_decoder instantiated once.

Verification
REQ-034 Accept ADD 0x0600: reg1=1, reg2=2 and reg_read=1 one cycle after accept; alu_code=1000 at +2; reg_write=1 at +3; instr_ready=1 at +4.
REQ-035 Accept LOAD 0x4C3A, with mem_ack held low for 4 cycles: mem_adr=0x3A, mem_we=0 and mem_req stay stable; reg_write=1 with reg1=3 one cycle after mem_ack.
REQ-036 Accept STORE 0x6510, then mem_ack: mem_we=1 and mem_adr=0x10, reg_write never asserted, and the FSM returns to IDLE.
REQ-037 Accept BRANCH 0xF0AA twice, with alu_flag=1 then alu_flag=0: the first gives pc_jump=1 and pc_target=0xAA; the second gives pc_jump=0. Accept JUMP 0x8055: pc_jump=1 and pc_target=0x55.
REQ-038 Pull rst_n low during MEM: mem_req falls without a clock edge, and a mem_ack arriving after reset has no effect.
REQ-039 Accept opcode 0x3 with the macro defined: trap=1 is sticky and instr_ready=0. With the macro undefined: no strobes and IDLE after 2 cycles. Macro defined and no mem_ack for 15 cycles: trap=1.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the sequencer control unit: opcodes, ALU codes,
// FSM state encoding and the decoded control bundle.
package ctrl_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0010;
  localparam logic [3:0] OP_LOAD  = 4'b0100;
  localparam logic [3:0] OP_STORE = 4'b0110;
  localparam logic [3:0] OP_JUMP  = 4'b1000;
  localparam logic [3:0] OP_BR0   = 4'b1101;
  localparam logic [3:0] OP_BR1   = 4'b1110;
  localparam logic [3:0] OP_BR2   = 4'b1111;

  localparam logic [3:0] ALU_ADD  = 4'b1000;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_MEM  = 4'b1001;
  localparam logic [3:0] ALU_NONE = 4'b0000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECODE,
    ST_EXEC,
    ST_MEM,
    ST_WB,
    ST_TRAP
  } state_t;

  // readBoth drives both register selects; readRs1 drives only reg1 (LOAD)
  typedef struct packed {
    logic       valid;
    logic       readBoth;
    logic       readRs1;
    logic       toMem;
    logic       toWb;
    logic       memWe;
    logic       jump;
    logic       branch;
    logic [3:0] aluCode;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational opcode decoder: maps a 4-bit opcode onto the control bundle
// that steers the sequencer FSM and its Moore outputs.
module ctrl_decoder
  import ctrl_pkg::*;
(
  input  logic [3:0] opcode_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (opcode_i)
      OP_ADD: begin
        ctrl_o.valid    = 1'b1;
        ctrl_o.readBoth = 1'b1;
        ctrl_o.toWb     = 1'b1;
        ctrl_o.aluCode  = ALU_ADD;
      end
      OP_SUB: begin
        ctrl_o.valid    = 1'b1;
        ctrl_o.readBoth = 1'b1;
        ctrl_o.toWb     = 1'b1;
        ctrl_o.aluCode  = ALU_SUB;
      end
      OP_LOAD: begin
        ctrl_o.valid    = 1'b1;
        ctrl_o.readRs1  = 1'b1;
        ctrl_o.toMem    = 1'b1;
        ctrl_o.toWb     = 1'b1;
        ctrl_o.aluCode  = ALU_MEM;
      end
      OP_STORE: begin
        ctrl_o.valid    = 1'b1;
        ctrl_o.readBoth = 1'b1;
        ctrl_o.toMem    = 1'b1;
        ctrl_o.memWe    = 1'b1;
        ctrl_o.aluCode  = ALU_MEM;
      end
      OP_JUMP: begin
        ctrl_o.valid    = 1'b1;
        ctrl_o.jump     = 1'b1;
        ctrl_o.aluCode  = ALU_NONE;
      end
      OP_BR0, OP_BR1, OP_BR2: begin
        ctrl_o.valid    = 1'b1;
        ctrl_o.readBoth = 1'b1;
        ctrl_o.branch   = 1'b1;
        ctrl_o.aluCode  = opcode_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/seq_control_unit.sv
// Multi-cycle instruction sequencer (IDLE/DECODE/EXEC/MEM/WB/TRAP).
// Optional macro SEQ_CTRL_TRAP_EN enables illegal-opcode and memory-timeout traps.
module seq_control_unit
  import ctrl_pkg::*;
#(
  parameter int INSTR_W     = 16,
  parameter int REG_ADR_W   = 2,
  parameter int MEM_ADR_W   = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_valid,
  output logic                 instr_ready,
  input  logic [INSTR_W-1:0]   instr,
  output logic [3:0]           alu_code,
  input  logic                 alu_flag,
  output logic [REG_ADR_W-1:0] reg1,
  output logic [REG_ADR_W-1:0] reg2,
  output logic                 reg_read,
  output logic                 reg_write,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [MEM_ADR_W-1:0] mem_adr,
  input  logic                 mem_ack,
  output logic                 pc_jump,
  output logic [MEM_ADR_W-1:0] pc_target,
  output logic                 busy,
  output logic                 trap
);

  if (INSTR_W < 4 + 2*REG_ADR_W + MEM_ADR_W || MEM_TIMEOUT < 1) begin : g_param_check
    $error("seq_control_unit: INSTR_W too narrow for its fields or MEM_TIMEOUT < 1");
  end

  state_t               state_q;
  logic [INSTR_W-1:0]   instr_q;
  ctrl_t                ctrl;
  logic [3:0]           opcode;
  logic [REG_ADR_W-1:0] rs1;
  logic [REG_ADR_W-1:0] rs2;
  logic [MEM_ADR_W-1:0] adr;
  logic                 memTimeout;

  assign opcode = instr_q[INSTR_W-1 -: 4];
  assign rs1    = instr_q[INSTR_W-5 -: REG_ADR_W];
  assign rs2    = instr_q[INSTR_W-5-REG_ADR_W -: REG_ADR_W];
  assign adr    = instr_q[MEM_ADR_W-1:0];

  ctrl_decoder u_decoder (
    .opcode_i (opcode),
    .ctrl_o   (ctrl)
  );

`ifdef SEQ_CTRL_TRAP_EN
  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
  logic [TO_W-1:0] timeout_q;

  // Counts consecutive MEM cycles without an acknowledge; cleared elsewhere
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timeout_q <= '0;
    end else if (state_q == ST_MEM && !mem_ack) begin
      timeout_q <= timeout_q + TO_W'(1);
    end else begin
      timeout_q <= '0;
    end
  end

  assign memTimeout = (timeout_q == TO_W'(MEM_TIMEOUT - 1));
`else
  assign memTimeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      instr_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (instr_valid) begin
            instr_q <= instr;
            state_q <= ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (ctrl.valid) begin
            state_q <= ST_EXEC;
          end else begin
`ifdef SEQ_CTRL_TRAP_EN
            state_q <= ST_TRAP;
`else
            state_q <= ST_IDLE;
`endif
          end
        end
        ST_EXEC: begin
          if (ctrl.toMem) begin
            state_q <= ST_MEM;
          end else if (ctrl.toWb) begin
            state_q <= ST_WB;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_MEM: begin
          if (mem_ack) begin
            state_q <= ctrl.toWb ? ST_WB : ST_IDLE;
          end else if (memTimeout) begin
            state_q <= ST_TRAP;
          end
        end
        ST_WB:   state_q <= ST_IDLE;
        ST_TRAP: state_q <= ST_TRAP;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Moore outputs; ready is qualified by rst_n so everything reads 0 in reset
  always_comb begin
    instr_ready = 1'b0;
    busy        = 1'b0;
    trap        = 1'b0;
    alu_code    = '0;
    reg1        = '0;
    reg2        = '0;
    reg_read    = 1'b0;
    reg_write   = 1'b0;
    mem_req     = 1'b0;
    mem_we      = 1'b0;
    mem_adr     = '0;
    pc_jump     = 1'b0;
    pc_target   = '0;
    case (state_q)
      ST_IDLE: instr_ready = rst_n;
      ST_DECODE: begin
        busy = 1'b1;
        if (ctrl.readBoth) begin
          reg1     = rs1;
          reg2     = rs2;
          reg_read = 1'b1;
        end else if (ctrl.readRs1) begin
          reg1 = rs1;
        end
      end
      ST_EXEC: begin
        busy     = 1'b1;
        alu_code = ctrl.aluCode;
        if (ctrl.jump || ctrl.branch) begin
          pc_jump   = ctrl.jump | alu_flag;
          pc_target = adr;
        end
      end
      ST_MEM: begin
        busy    = 1'b1;
        mem_req = 1'b1;
        mem_we  = ctrl.memWe;
        mem_adr = adr;
      end
      ST_WB: begin
        busy      = 1'b1;
        reg_write = 1'b1;
        reg1      = rs1;
      end
      ST_TRAP: begin
        busy = 1'b1;
`ifdef SEQ_CTRL_TRAP_EN
        trap = 1'b1;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seq_control_unit.sv
// Self-checking bench for seq_control_unit: per-cycle output traces are
// predicted from the instruction semantics and compared against the DUT.
module tb_seq_control_unit;

  localparam int INSTR_W     = 16;
  localparam int REG_ADR_W   = 2;
  localparam int MEM_ADR_W   = 8;
  localparam int MEM_TIMEOUT = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = '0;
  logic        alu_flag = 1'b0;
  logic        mem_ack = 1'b0;
  logic        instr_ready, reg_read, reg_write, mem_req, mem_we, pc_jump, busy, trap;
  logic [3:0]  alu_code;
  logic [1:0]  reg1, reg2;
  logic [7:0]  mem_adr, pc_target;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic       ready;
    logic       busy;
    logic [1:0] reg1;
    logic [1:0] reg2;
    logic       regRead;
    logic       regWrite;
    logic [3:0] alu;
    logic       memReq;
    logic       memWe;
    logic [7:0] memAdr;
    logic       pcJump;
    logic [7:0] pcTarget;
    logic       trap;
  } outs_t;

  outs_t expQ[$];
  bit    ackQ[$];
  bit    endsInTrap;

  seq_control_unit #(
    .INSTR_W(INSTR_W), .REG_ADR_W(REG_ADR_W),
    .MEM_ADR_W(MEM_ADR_W), .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .alu_code(alu_code), .alu_flag(alu_flag),
    .reg1(reg1), .reg2(reg2), .reg_read(reg_read), .reg_write(reg_write),
    .mem_req(mem_req), .mem_we(mem_we), .mem_adr(mem_adr), .mem_ack(mem_ack),
    .pc_jump(pc_jump), .pc_target(pc_target), .busy(busy), .trap(trap)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic outs_t observed();
    outs_t o;
    o.ready    = instr_ready;
    o.busy     = busy;
    o.reg1     = reg1;
    o.reg2     = reg2;
    o.regRead  = reg_read;
    o.regWrite = reg_write;
    o.alu      = alu_code;
    o.memReq   = mem_req;
    o.memWe    = mem_we;
    o.memAdr   = mem_adr;
    o.pcJump   = pc_jump;
    o.pcTarget = pc_target;
    o.trap     = trap;
    return o;
  endfunction

  function automatic outs_t idleVec();
    outs_t v = '0;
    v.ready = 1'b1;
    return v;
  endfunction

  function automatic logic [3:0] aluFor(input logic [3:0] op);
    case (op)
      4'h0:             return 4'b1000;
      4'h2:             return 4'b0100;
      4'h4, 4'h6:       return 4'b1001;
      4'hD, 4'hE, 4'hF: return op;
      default:          return 4'b0000;
    endcase
  endfunction

  function automatic void pushTrap();
    outs_t v = '0;
    v.busy = 1'b1;
    v.trap = 1'b1;
    for (int k = 0; k < 3; k++) begin
      expQ.push_back(v);
      ackQ.push_back(1'($urandom_range(0, 1)));
    end
    endsInTrap = 1'b1;
  endfunction

  // Expected per-cycle outputs after the accept edge, up to the return to idle
  function automatic void buildTrace(input logic [15:0] word, input int ackDelay, input bit flag);
    logic [3:0] op;
    logic [1:0] rs1, rs2;
    logic [7:0] adr;
    bit isBr, known, isMem;
    outs_t v;
    op = word[15:12];
    rs1 = word[11:10];
    rs2 = word[9:8];
    adr = word[7:0];
    isBr = (op == 4'hD || op == 4'hE || op == 4'hF);
    isMem = (op == 4'h4 || op == 4'h6);
    known = isBr || isMem || op == 4'h0 || op == 4'h2 || op == 4'h8;
    expQ.delete();
    ackQ.delete();
    endsInTrap = 1'b0;

    v = '0;
    v.busy = 1'b1;
    if (op == 4'h0 || op == 4'h2 || op == 4'h6 || isBr) begin
      v.reg1 = rs1;
      v.reg2 = rs2;
      v.regRead = 1'b1;
    end else if (op == 4'h4) begin
      v.reg1 = rs1;
    end
    expQ.push_back(v);
    ackQ.push_back(1'($urandom_range(0, 1)));

    if (!known) begin
`ifdef SEQ_CTRL_TRAP_EN
      pushTrap();
`else
      expQ.push_back(idleVec());
      ackQ.push_back(1'($urandom_range(0, 1)));
`endif
      return;
    end

    v = '0;
    v.busy = 1'b1;
    v.alu = aluFor(op);
    if (op == 4'h8) begin
      v.pcJump = 1'b1;
      v.pcTarget = adr;
    end else if (isBr) begin
      v.pcJump = flag;
      v.pcTarget = adr;
    end
    expQ.push_back(v);
    ackQ.push_back(1'($urandom_range(0, 1)));

    if (isMem) begin
      for (int k = 0; k <= ackDelay; k++) begin
`ifdef SEQ_CTRL_TRAP_EN
        if (k == MEM_TIMEOUT) begin
          pushTrap();
          return;
        end
`endif
        v = '0;
        v.busy = 1'b1;
        v.memReq = 1'b1;
        v.memWe = (op == 4'h6);
        v.memAdr = adr;
        expQ.push_back(v);
        ackQ.push_back(k == ackDelay);
      end
    end

    if (op == 4'h0 || op == 4'h2 || op == 4'h4) begin
      v = '0;
      v.busy = 1'b1;
      v.regWrite = 1'b1;
      v.reg1 = rs1;
      expQ.push_back(v);
      ackQ.push_back(1'($urandom_range(0, 1)));
    end
    expQ.push_back(idleVec());
    ackQ.push_back(1'($urandom_range(0, 1)));
  endfunction

  // Enter and leave at a falling edge with the DUT idle
  task automatic doReset();
    #2;
    rst_n = 1'b0;
    instr_valid = 1'($urandom_range(0, 1));
    mem_ack = 1'b1;
    #1;
    checks++;
    if (observed() !== outs_t'('0)) begin
      failures++;
      $display("[TB] FAIL reset_async got %h expected %h", observed(), outs_t'('0));
    end
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (observed() !== outs_t'('0)) begin
      failures++;
      $display("[TB] FAIL reset_held got %h expected %h", observed(), outs_t'('0));
    end
    instr_valid = 1'b0;
    mem_ack = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (observed() !== idleVec()) begin
      failures++;
      $display("[TB] FAIL reset_release got %h expected %h", observed(), idleVec());
    end
  endtask

  task automatic applyStimulus(input logic [15:0] word, input int ackDelay, input bit flag,
                               input string name);
    buildTrace(word, ackDelay, flag);
    instr_valid = 1'b1;
    instr = word;
    alu_flag = flag;
    mem_ack = 1'b0;
    @(posedge clk);
    for (int i = 0; i < expQ.size(); i++) begin
      #1;
      mem_ack = ackQ[i];
      if (i == expQ.size() - 1) begin
        instr_valid = 1'b0;
      end else begin
        instr_valid = 1'($urandom_range(0, 1));
        instr = 16'($urandom);
      end
      @(negedge clk);
      checks++;
      if (observed() !== expQ[i]) begin
        failures++;
        $display("[TB] FAIL %s word=%h cycle+%0d got %h expected %h",
                 name, word, i + 1, observed(), expQ[i]);
      end
      if (i != expQ.size() - 1) @(posedge clk);
    end
    mem_ack = 1'b0;
    instr_valid = 1'b0;
    if (endsInTrap) doReset();
  endtask

  task automatic test_reset();
    @(negedge clk);
    doReset();
  endtask

  task automatic test_directed();
    applyStimulus(16'h0600, 0, 1'b0, "add");
    applyStimulus(16'h4C3A, 4, 1'b0, "load_wait4");
    applyStimulus(16'h6510, 0, 1'b0, "store");
    applyStimulus(16'hF0AA, 0, 1'b1, "branch_taken");
    applyStimulus(16'hF0AA, 0, 1'b0, "branch_not_taken");
    applyStimulus(16'h8055, 0, 1'b0, "jump");
    applyStimulus(16'h2B00, 2, 1'b1, "sub");
  endtask

  task automatic test_back_to_back();
    logic [3:0] ops [8];
    logic [3:0] op;
    ops = '{4'h0, 4'h2, 4'h4, 4'h6, 4'h8, 4'hD, 4'hE, 4'hF};
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        op = 4'h1 + 4'(2 * $urandom_range(0, 2));
      end else begin
        op = ops[$urandom_range(0, 7)];
      end
      applyStimulus({op, 12'($urandom)}, int'($urandom_range(0, 6)),
                    1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_reset_mid_mem();
    instr_valid = 1'b1;
    instr = 16'h4C3A;
    mem_ack = 1'b0;
    @(posedge clk);
    #1 instr_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (mem_req !== 1'b1) begin
      failures++;
      $display("[TB] FAIL mid_mem_req got %b expected 1", mem_req);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (mem_req !== 1'b0) begin
      failures++;
      $display("[TB] FAIL mid_mem_async_drop got %b expected 0", mem_req);
    end
    mem_ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (observed() !== idleVec()) begin
        failures++;
        $display("[TB] FAIL late_ack_ignored cycle %0d got %h expected %h",
                 i, observed(), idleVec());
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_undefined_and_timeout();
    applyStimulus(16'h3123, 0, 1'b0, "undef_op");
    applyStimulus(16'hB0FF, 0, 1'b1, "undef_op_b");
`ifdef SEQ_CTRL_TRAP_EN
    applyStimulus(16'h4C3A, MEM_TIMEOUT + 2, 1'b0, "mem_timeout");
    applyStimulus(16'h6510, MEM_TIMEOUT - 1, 1'b0, "mem_ack_last_cycle");
`else
    applyStimulus(16'h4C3A, 20, 1'b0, "mem_long_wait");
`endif
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_mid_mem();
    test_undefined_and_timeout();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
